uart_rx_sequencer: RTL and testbench
====================================

# uart_rx_sequencer

Self-contained UART receive controller that sequences the full 8N1 receive datapath: input synchronizer, x16 baud-tick generator, oversample and bit counters, shift register, output holding register and error flags. It replaces externally driven counter-done strobes with internally generated ones. It presents received bytes to downstream logic through a valid/ready handshake and exports its FSM state for debug.

## Interface

- CLK_FREQ, 125_000_000, input clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s
- DATA_BITS, 8, data bits per frame (1..8)
- Derived: DIV = CLK_FREQ/(BAUD_RATE*16), integer truncation, 813 at defaults; one bit time = 16*DIV clocks.

- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  asynchronous, active-low reset
- RXD  input  1  serial line; idle high; asynchronous to CLK
- RX_READY  input  1  downstream accepts byte
- RX_DATA  output  8  received byte, LSB = first data bit
- RX_VALID  output  1  RX_DATA holds an unaccepted byte
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled 0
- OVERRUN  output  1  one-cycle pulse: frame completed while previous byte unaccepted
- BAUD_X16_EN  output  1  one-cycle x16 oversample tick
- fsm_state  output  2  0 IDLE, 1 START, 2 DATA, 3 STOP

## Operation

- RXD passes through a 2-flop synchronizer, reset value 1; rxd_s is the synchronized signal.
- Tick generator: counter 0..DIV-1, held at 0 in IDLE, runs in the other states; BAUD_X16_EN = 1 when counter == DIV-1.
- os_cnt is a 4-bit counter incremented on each tick and cleared on every state change. bit_cnt is a 3-bit counter.
- IDLE: when rxd_s == 0 and armed == 1 -> START.
- START: on the tick that makes os_cnt reach 7 (mid start bit), check the sampled value:
  - 0 -> DATA, bit_cnt = 0.
  - 1 -> IDLE (glitch); no flags.
- DATA: on each tick where os_cnt == 15, shift the sampled bit in, LSB first, and increment bit_cnt. After DATA_BITS samples -> STOP. Unused high bits of RX_DATA are 0 when DATA_BITS < 8.
- STOP: on the tick where os_cnt == 15, sample the stop bit, then -> IDLE.
  - 1: load RX_DATA, set RX_VALID (overrun rules apply).
  - 0: pulse FRAME_ERR, discard the byte, clear armed.
- armed is set when rxd_s == 1 in IDLE and reset to 1. A break/low line after a framing error therefore cannot retrigger.
- Handshake: RX_VALID clears on a posedge where RX_VALID && RX_READY. RX_DATA is stable while RX_VALID = 1.
- Overrun: a good stop while RX_VALID = 1 and not accepted in the same cycle pulses OVERRUN, drops the new byte and keeps the old RX_DATA.
- Acceptance and a new good stop in the same cycle: the new byte is loaded, RX_VALID stays 1, no OVERRUN.
- Reset (RST = 0), including mid-frame, asynchronously forces:
  - fsm_state = 0, RX_DATA = 8'h00
  - RX_VALID, FRAME_ERR, OVERRUN, BAUD_X16_EN = 0
  - all counters 0, armed = 1

## Timing

- Falling RXD edge -> fsm_state = 1 at the 3rd rising CLK edge (2 sync + 1).
- Start-bit check at 8*DIV clocks after START entry. Each data sample follows 16*DIV clocks after the previous sample.
- RX_VALID or FRAME_ERR rises the cycle after the stop sample, about 9.5 bit times (~123.6k clocks at defaults) after the start edge. fsm_state returns to 0 in the same cycle.
- FRAME_ERR and OVERRUN are exactly one CLK wide. RX_VALID has no combinational path from RX_READY.

## Configuration

- UART_RX_MAJORITY_EN defined:
  - A 3-bit history of rxd_s is captured on each BAUD_X16_EN.
  - The sampled value is the majority of the three, so a single-tick glitch is rejected.
  - Start detection in IDLE still uses raw rxd_s.
- Undefined: the sampled value is rxd_s at the tick. No history register is present.

## Test plan

- Hold RST = 0 for 10 clocks -> fsm_state = 0, RX_DATA = 8'h00, RX_VALID = FRAME_ERR = OVERRUN = BAUD_X16_EN = 0; release -> still IDLE with RXD = 1.
- Send 8'hA5 8N1 at 9600 with RX_READY = 1 -> fsm_state steps 0,1,2,3,0; RX_VALID high exactly one cycle with RX_DATA = 8'hA5; no flags.
- Drive RXD low for 2000 clocks (< 8*DIV = 6504) -> START then back to IDLE; RX_VALID, FRAME_ERR, OVERRUN stay 0.
- Send 8'h3C with stop bit 0, then hold RXD low 2 bit times -> one FRAME_ERR pulse; RX_VALID stays 0; fsm stays IDLE until RXD returns high; a following 8'h3C with a good stop is received.
- RX_READY = 0; send 8'h11 then 8'h22 -> RX_VALID = 1 with RX_DATA = 8'h11; OVERRUN pulses at the second frame end and RX_DATA remains 8'h11; assert RX_READY -> RX_VALID clears next edge.
- Pull RST low mid-DATA of 8'hFF -> outputs take reset values immediately; after release, 8'h5A is received correctly. With UART_RX_MAJORITY_EN, a 1-tick high glitch in a data bit of 8'h00 still yields RX_DATA = 8'h00.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: 8N1 UART receiver with its own synchronizer, x16 baud
// tick generator, oversample/bit counters, shift register, holding register,
// valid/ready output handshake and error pulses.
// Optional build macro UART_RX_MAJORITY_EN: bit samples are a 3-tick majority
// vote of the synchronized line instead of a single sample.
module uart_rx_sequencer #(
   parameter int CLK_FREQ  = 125_000_000,
   parameter int BAUD_RATE = 9600,
   parameter int DATA_BITS = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RXD,
   input  logic       RX_READY,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   output logic       FRAME_ERR,
   output logic       OVERRUN,
   output logic       BAUD_X16_EN,
   output logic [1:0] fsm_state
);

   localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q;
   logic             sync1_q;
   logic             rxdS_q;
   logic [DIV_W-1:0] divCnt_q;
   logic [3:0]       osCnt_q;
   logic [2:0]       bitCnt_q;
   logic [7:0]       shift_q;
   logic [7:0]       shift_d;
   logic [7:0]       rxData_q;
   logic             rxValid_q;
   logic             frameErr_q;
   logic             overrun_q;
   logic             armed_q;
   logic             sample_d;
   logic             tick;

`ifdef UART_RX_MAJORITY_EN
   logic [2:0]       hist_q;
`endif

   // The divider is held at zero in IDLE, so the oversample tick only exists while a frame is in progress.
   assign tick = (state_q != IDLE) && (divCnt_q == DIV_LAST);

   // Bit value used at a sampling tick and the shift register's next value with that bit inserted at the top data position.
   always_comb begin
`ifdef UART_RX_MAJORITY_EN
      sample_d = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxdS_q) | (hist_q[0] & rxdS_q);
`else
      sample_d = rxdS_q;
`endif
      shift_d = shift_q >> 1;
      shift_d[DATA_BITS-1] = sample_d;
   end

`ifdef UART_RX_MAJORITY_EN
   // Rolling history of the synchronized line, advanced once per oversample tick.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hist_q <= 3'b111;
      end else if (tick) begin
         hist_q <= {hist_q[1:0], rxdS_q};
      end
   end
`endif

   // Receive sequencer: synchronizer, counters, shift register, holding register, handshake and error pulses.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         sync1_q    <= 1'b1;
         rxdS_q     <= 1'b1;
         divCnt_q   <= '0;
         osCnt_q    <= 4'd0;
         bitCnt_q   <= 3'd0;
         shift_q    <= 8'h00;
         rxData_q   <= 8'h00;
         rxValid_q  <= 1'b0;
         frameErr_q <= 1'b0;
         overrun_q  <= 1'b0;
         armed_q    <= 1'b1;
      end else begin
         sync1_q    <= RXD;
         rxdS_q     <= sync1_q;
         frameErr_q <= 1'b0;
         overrun_q  <= 1'b0;

         if (rxValid_q && RX_READY) begin
            rxValid_q <= 1'b0;
         end

         if (state_q == IDLE || tick) begin
            divCnt_q <= '0;
         end else begin
            divCnt_q <= divCnt_q + 1'b1;
         end

         case (state_q)
            IDLE: begin
               osCnt_q <= 4'd0;
               if (rxdS_q) begin
                  armed_q <= 1'b1;
               end
               if (!rxdS_q && armed_q) begin
                  state_q <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (osCnt_q == 4'd7) begin
                     osCnt_q <= 4'd0;
                     if (!sample_d) begin
                        state_q  <= DATA;
                        bitCnt_q <= 3'd0;
                        shift_q  <= 8'h00;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     osCnt_q <= osCnt_q + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  osCnt_q <= osCnt_q + 4'd1;
                  if (osCnt_q == 4'd15) begin
                     shift_q  <= shift_d;
                     bitCnt_q <= bitCnt_q + 3'd1;
                     if (bitCnt_q == LAST_BIT) begin
                        state_q <= STOP;
                        osCnt_q <= 4'd0;
                     end
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  osCnt_q <= osCnt_q + 4'd1;
                  if (osCnt_q == 4'd15) begin
                     state_q <= IDLE;
                     osCnt_q <= 4'd0;
                     if (sample_d) begin
                        if (rxValid_q && !RX_READY) begin
                           overrun_q <= 1'b1;
                        end else begin
                           rxData_q  <= shift_q;
                           rxValid_q <= 1'b1;
                        end
                     end else begin
                        frameErr_q <= 1'b1;
                        armed_q    <= 1'b0;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign RX_DATA     = rxData_q;
   assign RX_VALID    = rxValid_q;
   assign FRAME_ERR   = frameErr_q;
   assign OVERRUN     = overrun_q;
   assign BAUD_X16_EN = tick;
   assign fsm_state   = state_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// tb_uart_rx_sequencer: directed frame vectors plus hand-written corner
// sequences for uart_rx_sequencer, scaled to DIV = 10 (160 clocks per bit).
// Build macro UART_RX_MAJORITY_EN additionally enables the glitch-rejection case.
module tb_uart_rx_sequencer;

   localparam int CLK_FREQ  = 1_600_000;
   localparam int BAUD_RATE = 10_000;
   localparam int DIV       = 10;
   localparam int BIT       = 16 * DIV;
   localparam int FRAME_TICKS = 8 + 16 * 9;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RXD = 1'b1;
   logic       RX_READY = 1'b1;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic       FRAME_ERR;
   logic       OVERRUN;
   logic       BAUD_X16_EN;
   logic [1:0] fsm_state;

   uart_rx_sequencer #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE),
      .DATA_BITS(8)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RXD        (RXD),
      .RX_READY   (RX_READY),
      .RX_DATA    (RX_DATA),
      .RX_VALID   (RX_VALID),
      .FRAME_ERR  (FRAME_ERR),
      .OVERRUN    (OVERRUN),
      .BAUD_X16_EN(BAUD_X16_EN),
      .fsm_state  (fsm_state)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] data;
      logic       stopBit;
      logic [7:0] expData;
      int         expValid;
      int         expFe;
   } vec_t;

   vec_t vecs[6];

   int vectorsApplied = 0;
   int missCount = 0;

   // Event monitor, sampled on the falling edge away from the active edge.
   int         validHigh = 0;
   int         feCount = 0;
   int         ovCount = 0;
   int         tickCount = 0;
   int         wideFlags = 0;
   logic [7:0] capturedData = 8'h00;
   logic [1:0] prevState = 2'd0;
   logic       prevFe = 1'b0;
   logic       prevOv = 1'b0;
   logic [1:0] stateLog[$];

   // Tally output events and log every change of the exported FSM state.
   always @(negedge CLK) begin
      if (RX_VALID) begin
         validHigh++;
         capturedData = RX_DATA;
      end
      if (FRAME_ERR) feCount++;
      if (OVERRUN) ovCount++;
      if (BAUD_X16_EN) tickCount++;
      if ((FRAME_ERR && prevFe) || (OVERRUN && prevOv)) wideFlags++;
      prevFe = FRAME_ERR;
      prevOv = OVERRUN;
      if (fsm_state != prevState) stateLog.push_back(fsm_state);
      prevState = fsm_state;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectorsApplied++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Hold the line at one level for a number of clocks; returns 1 time unit after a rising edge.
   task automatic driveBit(input logic b, input int clocks);
      RXD = b;
      repeat (clocks) @(posedge CLK);
      #1;
   endtask

   // One 8N1 frame followed by one bit time of idle line.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      driveBit(1'b0, BIT);
      for (int i = 0; i < 8; i++) driveBit(data[i], BIT);
      driveBit(stopBit, BIT);
      driveBit(1'b1, BIT);
   endtask

   int v0, f0, o0, t0, s0;

   initial begin
      vecs[0] = '{data: 8'hA5, stopBit: 1'b1, expData: 8'hA5, expValid: 1, expFe: 0};
      vecs[1] = '{data: 8'h3C, stopBit: 1'b0, expData: 8'h00, expValid: 0, expFe: 1};
      vecs[2] = '{data: 8'h00, stopBit: 1'b1, expData: 8'h00, expValid: 1, expFe: 0};
      vecs[3] = '{data: 8'hFF, stopBit: 1'b1, expData: 8'hFF, expValid: 1, expFe: 0};
      vecs[4] = '{data: 8'h81, stopBit: 1'b1, expData: 8'h81, expValid: 1, expFe: 0};
      vecs[5] = '{data: 8'h4B, stopBit: 1'b1, expData: 8'h4B, expValid: 1, expFe: 0};

      // Reset values while held.
      RST = 1'b0;
      RXD = 1'b1;
      RX_READY = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      checkOutput("rst_fsm", 32'(fsm_state), 32'd0);
      checkOutput("rst_data", 32'(RX_DATA), 32'h00);
      checkOutput("rst_valid", 32'(RX_VALID), 32'd0);
      checkOutput("rst_fe", 32'(FRAME_ERR), 32'd0);
      checkOutput("rst_ov", 32'(OVERRUN), 32'd0);
      checkOutput("rst_tick", 32'(BAUD_X16_EN), 32'd0);
      RST = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      checkOutput("post_rst_fsm", 32'(fsm_state), 32'd0);
      checkOutput("post_rst_valid", 32'(RX_VALID), 32'd0);

      // Table-driven frames with the receiver always ready.
      for (int i = 0; i < 6; i++) begin
         v0 = validHigh; f0 = feCount; o0 = ovCount; t0 = tickCount; s0 = stateLog.size();
         applyStimulus(vecs[i].data, vecs[i].stopBit);
         checkOutput($sformatf("v%0d_valid_cycles", i), 32'(validHigh - v0), 32'(vecs[i].expValid));
         checkOutput($sformatf("v%0d_fe", i), 32'(feCount - f0), 32'(vecs[i].expFe));
         checkOutput($sformatf("v%0d_ov", i), 32'(ovCount - o0), 32'd0);
         checkOutput($sformatf("v%0d_ticks", i), 32'(tickCount - t0), 32'(FRAME_TICKS));
         checkOutput($sformatf("v%0d_fsm_end", i), 32'(fsm_state), 32'd0);
         if (vecs[i].expValid != 0)
            checkOutput($sformatf("v%0d_data", i), 32'(capturedData), 32'(vecs[i].expData));
         checkOutput($sformatf("v%0d_state_steps", i), 32'(stateLog.size() - s0), 32'd4);
         if (stateLog.size() - s0 == 4) begin
            checkOutput($sformatf("v%0d_seq0", i), 32'(stateLog[s0]), 32'd1);
            checkOutput($sformatf("v%0d_seq1", i), 32'(stateLog[s0+1]), 32'd2);
            checkOutput($sformatf("v%0d_seq2", i), 32'(stateLog[s0+2]), 32'd3);
            checkOutput($sformatf("v%0d_seq3", i), 32'(stateLog[s0+3]), 32'd0);
         end
      end

      // Short low pulse: START entered, start check sees 1, back to IDLE silently.
      v0 = validHigh; f0 = feCount; o0 = ovCount; t0 = tickCount; s0 = stateLog.size();
      driveBit(1'b0, 5 * DIV);
      driveBit(1'b1, 2 * BIT);
      checkOutput("glitch_steps", 32'(stateLog.size() - s0), 32'd2);
      if (stateLog.size() - s0 == 2) begin
         checkOutput("glitch_seq0", 32'(stateLog[s0]), 32'd1);
         checkOutput("glitch_seq1", 32'(stateLog[s0+1]), 32'd0);
      end
      checkOutput("glitch_ticks", 32'(tickCount - t0), 32'd8);
      checkOutput("glitch_valid", 32'(validHigh - v0), 32'd0);
      checkOutput("glitch_fe", 32'(feCount - f0), 32'd0);
      checkOutput("glitch_ov", 32'(ovCount - o0), 32'd0);

      // Framing error followed by a held-low line: no retrigger until the line goes high.
      v0 = validHigh; f0 = feCount;
      driveBit(1'b0, BIT);
      for (int i = 0; i < 8; i++) driveBit(((8'h3C >> i) & 8'h01) != 8'h00, BIT);
      driveBit(1'b0, BIT);
      s0 = stateLog.size();
      driveBit(1'b0, 2 * BIT);
      checkOutput("brk_fe", 32'(feCount - f0), 32'd1);
      checkOutput("brk_valid", 32'(validHigh - v0), 32'd0);
      checkOutput("brk_no_retrigger", 32'(stateLog.size() - s0), 32'd0);
      checkOutput("brk_fsm", 32'(fsm_state), 32'd0);
      driveBit(1'b1, 2 * BIT);
      v0 = validHigh;
      applyStimulus(8'h3C, 1'b1);
      checkOutput("brk_recover_valid", 32'(validHigh - v0), 32'd1);
      checkOutput("brk_recover_data", 32'(capturedData), 32'h3C);

      // Overrun: first byte held unaccepted, second frame dropped.
      RX_READY = 1'b0;
      applyStimulus(8'h11, 1'b1);
      checkOutput("ovr_valid1", 32'(RX_VALID), 32'd1);
      checkOutput("ovr_data1", 32'(RX_DATA), 32'h11);
      o0 = ovCount;
      applyStimulus(8'h22, 1'b1);
      checkOutput("ovr_pulse", 32'(ovCount - o0), 32'd1);
      checkOutput("ovr_data_kept", 32'(RX_DATA), 32'h11);
      checkOutput("ovr_valid_kept", 32'(RX_VALID), 32'd1);
      RX_READY = 1'b1;
      @(posedge CLK);
      #1;
      checkOutput("ovr_accept_clears", 32'(RX_VALID), 32'd0);

      // Asynchronous reset in the middle of the data bits of 8'hFF.
      driveBit(1'b0, BIT);
      driveBit(1'b1, 3 * BIT);
      checkOutput("midrst_in_data", 32'(fsm_state), 32'd2);
      #2;
      RST = 1'b0;
      #1;
      checkOutput("midrst_fsm", 32'(fsm_state), 32'd0);
      checkOutput("midrst_data", 32'(RX_DATA), 32'h00);
      checkOutput("midrst_valid", 32'(RX_VALID), 32'd0);
      checkOutput("midrst_fe", 32'(FRAME_ERR), 32'd0);
      checkOutput("midrst_ov", 32'(OVERRUN), 32'd0);
      checkOutput("midrst_tick", 32'(BAUD_X16_EN), 32'd0);
      repeat (5) @(posedge CLK);
      #1;
      RST = 1'b1;
      driveBit(1'b1, 2 * BIT);
      v0 = validHigh;
      applyStimulus(8'h5A, 1'b1);
      checkOutput("midrst_recover_valid", 32'(validHigh - v0), 32'd1);
      checkOutput("midrst_recover_data", 32'(capturedData), 32'h5A);

`ifdef UART_RX_MAJORITY_EN
      // One-tick high glitch centred on the bit-3 sample of 8'h00 is outvoted.
      v0 = validHigh;
      driveBit(1'b0, BIT);
      driveBit(1'b0, 3 * BIT);
      driveBit(1'b0, 75);
      driveBit(1'b1, DIV);
      driveBit(1'b0, BIT - 75 - DIV);
      driveBit(1'b0, 4 * BIT);
      driveBit(1'b1, BIT);
      driveBit(1'b1, BIT);
      checkOutput("maj_valid", 32'(validHigh - v0), 32'd1);
      checkOutput("maj_data", 32'(capturedData), 32'h00);
`endif

      checkOutput("flag_width", 32'(wideFlags), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, missCount);
      $finish;
   end

endmodule
